// File: rtl/motion_pkg.sv
// motion_pkg: command bytes, FSM state encoding and per-motor speed-class patterns
// shared by motion_cmd_ramp and its channels.
package motion_pkg;
   localparam logic [7:0] CMD_FOR   = "f";
   localparam logic [7:0] CMD_BCK   = "b";
   localparam logic [7:0] CMD_RHT   = "r";
   localparam logic [7:0] CMD_LFT   = "l";
   localparam logic [7:0] CMD_UPW   = "u";
   localparam logic [7:0] CMD_DNW   = "d";
   localparam logic [7:0] CMD_STOP  = "s";
   localparam logic [7:0] CMD_ESTOP = "e";
   localparam logic [7:0] ACK_ERR   = "?";

   typedef enum logic [1:0] {IDLE, DECODE, ACK} state_t;
   typedef enum logic [1:0] {ZERO, PULL, PUSH, DN} spd_cls_t;

   // Pattern tables packed as {m3, m2, m1, m0}, two bits per motor.
   localparam logic [7:0] PAT_FOR  = {PUSH, PUSH, PULL, PULL};
   localparam logic [7:0] PAT_BCK  = {PULL, PULL, PUSH, PUSH};
   localparam logic [7:0] PAT_RHT  = {PUSH, PULL, PULL, PUSH};
   localparam logic [7:0] PAT_LFT  = {PULL, PUSH, PUSH, PULL};
   localparam logic [7:0] PAT_UPW  = {PULL, PULL, PULL, PULL};
   localparam logic [7:0] PAT_DNW  = {DN, DN, DN, DN};
   localparam logic [7:0] PAT_ZERO = '0;

   function automatic logic cmd_known(input logic [7:0] c);
      return c inside {CMD_FOR, CMD_BCK, CMD_RHT, CMD_LFT, CMD_UPW, CMD_DNW, CMD_STOP, CMD_ESTOP};
   endfunction

   function automatic spd_cls_t cmd_pattern(input logic [7:0] c, input logic [1:0] m);
      logic [7:0] pat;
      pat = (c == CMD_FOR) ? PAT_FOR :
            (c == CMD_BCK) ? PAT_BCK :
            (c == CMD_RHT) ? PAT_RHT :
            (c == CMD_LFT) ? PAT_LFT :
            (c == CMD_UPW) ? PAT_UPW :
            (c == CMD_DNW) ? PAT_DNW : PAT_ZERO;
      return spd_cls_t'(pat[{m, 1'b0} +: 2]);
   endfunction
endpackage

// File: rtl/speed_ramp.sv
// speed_ramp: one motor channel; slews the current speed toward its target by
// RAMP_STEP on every shared tick, clamping at the target.
module speed_ramp #(
   parameter int SPD_W     = 9,
   parameter int RAMP_STEP = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_tick,
   input  logic             i_tgt_we,
   input  logic [SPD_W-1:0] i_tgt,
   input  logic             i_estop,
   output logic [SPD_W-1:0] o_cur,
   output logic [SPD_W-1:0] o_tgt
);
   localparam logic [SPD_W:0] STEP = (SPD_W+1)'(RAMP_STEP);

   logic [SPD_W-1:0] r_cur, r_tgt, w_next;
   logic [SPD_W:0]   w_up, w_dn, w_tgt_x;

   // One extra bit keeps the sum from wrapping and flags a negative difference.
   always_comb begin
      w_tgt_x = {1'b0, r_tgt};
      w_up    = {1'b0, r_cur} + STEP;
      w_dn    = {1'b0, r_cur} - STEP;
      w_next  = (r_cur < r_tgt) ? ((w_up > w_tgt_x) ? r_tgt : w_up[SPD_W-1:0]) :
                (r_cur > r_tgt) ? ((w_dn[SPD_W] || w_dn < w_tgt_x) ? r_tgt : w_dn[SPD_W-1:0]) :
                r_cur;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cur <= '0;
         r_tgt <= '0;
      end else if (i_estop) begin
         r_cur <= '0;
         r_tgt <= '0;
      end else begin
         if (i_tgt_we) r_tgt <= i_tgt;
         if (i_tick) r_cur <= w_next;
      end
   end

   assign o_cur = r_cur;
   assign o_tgt = r_tgt;
endmodule

// File: rtl/motion_cmd_ramp.sv
// motion_cmd_ramp: decodes UART command bytes into per-motor target speeds, ramps
// each motor toward its target, acknowledges every accepted byte, and guards with a watchdog.
module motion_cmd_ramp
   import motion_pkg::*;
#(
   parameter int               NUM_MOT   = 4,
   parameter int               SPD_W     = 9,
   parameter logic [SPD_W-1:0] SPD_PULL  = 9'h002,
   parameter logic [SPD_W-1:0] SPD_PUSH  = 9'h080,
   parameter logic [SPD_W-1:0] SPD_DN    = 9'h0FF,
   parameter int               RAMP_STEP = 8,
   parameter int               RAMP_DIV  = 1000,
   parameter int               WDOG_CYC  = 50_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   input  logic                     tx_ready,
   output logic                     tx_valid,
   output logic [7:0]               tx_data,
   output logic [NUM_MOT*SPD_W-1:0] speed,
   output logic                     ramping,
   output logic                     wdog_trip,
   output logic                     overrun
);
   localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int WD_W  = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

   state_t                   r_state;
   logic [7:0]               r_cmd, r_tx_data;
   logic                     r_tx_valid, r_ramping, r_wdog_trip, r_overrun;
   logic [DIV_W-1:0]         r_div;
   logic [WD_W-1:0]          r_wdog;
   logic                     w_tick, w_decode, w_wdog_hit, w_estop, w_tgt_we;
   logic [NUM_MOT-1:0]       w_neq;
   logic [NUM_MOT*SPD_W-1:0] w_cur, w_tgt;

   // An "e" arriving while busy is dropped from the FSM but still stops the motors.
   always_comb begin
      w_tick     = r_div == DIV_W'(RAMP_DIV - 1);
      w_decode   = r_state == DECODE;
      w_wdog_hit = (WDOG_CYC != 0) && !w_decode && (r_wdog == WD_W'(WDOG_CYC - 1));
      w_estop    = (w_decode && r_cmd == CMD_ESTOP) ||
                   (r_state != IDLE && rx_valid && rx_data == CMD_ESTOP);
      w_tgt_we   = (w_decode && cmd_known(r_cmd) && r_cmd != CMD_ESTOP) || w_wdog_hit;
   end

   for (genvar g = 0; g < NUM_MOT; g++) begin : g_mot
      spd_cls_t         w_cls;
      logic [SPD_W-1:0] w_val;
      always_comb begin
         w_cls = w_wdog_hit ? ZERO : cmd_pattern(r_cmd, 2'(g % 4));
         w_val = (w_cls == PULL) ? SPD_PULL :
                 (w_cls == PUSH) ? SPD_PUSH :
                 (w_cls == DN)   ? SPD_DN : '0;
      end
      speed_ramp #(
         .SPD_W     (SPD_W),
         .RAMP_STEP (RAMP_STEP)
      ) u_ramp (
         .clk      (clk),
         .rst      (rst),
         .i_tick   (w_tick),
         .i_tgt_we (w_tgt_we),
         .i_tgt    (w_val),
         .i_estop  (w_estop),
         .o_cur    (w_cur[g*SPD_W +: SPD_W]),
         .o_tgt    (w_tgt[g*SPD_W +: SPD_W])
      );
      assign w_neq[g] = w_cur[g*SPD_W +: SPD_W] != w_tgt[g*SPD_W +: SPD_W];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cmd       <= '0;
         r_tx_valid  <= 1'b0;
         r_tx_data   <= '0;
         r_ramping   <= 1'b0;
         r_wdog_trip <= 1'b0;
         r_overrun   <= 1'b0;
         r_div       <= '0;
         r_wdog      <= '0;
      end else begin
         r_div       <= w_tick ? '0 : r_div + 1'b1;
         r_wdog      <= (WDOG_CYC == 0 || w_decode || w_wdog_hit) ? '0 : r_wdog + 1'b1;
         r_wdog_trip <= w_wdog_hit;
         r_overrun   <= rx_valid && r_state != IDLE;
         r_ramping   <= |w_neq;
         case (r_state)
            IDLE: if (rx_valid) begin
               r_cmd   <= rx_data;
               r_state <= DECODE;
            end
            DECODE: begin
               r_tx_valid <= 1'b1;
               r_tx_data  <= cmd_known(r_cmd) ? r_cmd : ACK_ERR;
               r_state    <= ACK;
            end
            ACK: if (tx_ready) begin
               r_tx_valid <= 1'b0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tx_valid  = r_tx_valid;
   assign tx_data   = r_tx_data;
   assign speed     = w_cur;
   assign ramping   = r_ramping;
   assign wdog_trip = r_wdog_trip;
   assign overrun   = r_overrun;
endmodule

// File: tb/tb_motion_cmd_ramp.sv
// tb_motion_cmd_ramp: scenario tasks for motion_cmd_ramp with an acknowledge scoreboard
// and a per-tick speed model.
module tb_motion_cmd_ramp;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_ready = 1'b1;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic [35:0] speed;
   logic        ramping, wdog_trip, overrun;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  mon_exp;

   always #5 clk = ~clk;

   motion_cmd_ramp #(
      .NUM_MOT(4), .SPD_W(9), .SPD_PULL(9'h002), .SPD_PUSH(9'h080), .SPD_DN(9'h0FF),
      .RAMP_STEP(8), .RAMP_DIV(4), .WDOG_CYC(100)
   ) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .speed(speed), .ramping(ramping),
      .wdog_trip(wdog_trip), .overrun(overrun)
   );

   // Acknowledge scoreboard: every handshake pops the oldest expected byte.
   initial forever begin
      @(negedge clk);
      if (rst && tx_valid && tx_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL ack_unexpected got=%h", tx_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (tx_data !== mon_exp) begin
               failures++;
               $display("FAIL ack_byte got=%h exp=%h", tx_data, mon_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [8:0] mstep(input logic [8:0] c, input logic [8:0] t);
      int ci, ti;
      ci = int'(c);
      ti = int'(t);
      if (ci < ti) return (ci + 8 > ti) ? t : 9'(ci + 8);
      if (ci > ti) return (ci - 8 < ti) ? t : 9'(ci - 8);
      return c;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit push, input logic [7:0] ack);
      rx_valid = 1'b1;
      rx_data  = b;
      if (push) exp_q.push_back(ack);
      step(1);
      rx_valid = 1'b0;
   endtask

   task automatic ramp_watch(input logic [35:0] tgt, input string nm, output int ticks);
      logic [35:0] prev, cur, expv;
      int last;
      bit done;
      prev  = speed;
      ticks = 0;
      last  = -1;
      done  = (speed == tgt);
      for (int c = 0; c < 300 && !done; c++) begin
         rx_valid = (c % 50 == 49);
         rx_data  = "x";
         if (rx_valid) exp_q.push_back("?");
         step(1);
         rx_valid = 1'b0;
         cur = speed;
         if (cur !== prev) begin
            for (int m = 0; m < 4; m++) expv[m*9 +: 9] = mstep(prev[m*9 +: 9], tgt[m*9 +: 9]);
            checks++;
            if (cur !== expv) begin
               failures++;
               $display("FAIL %s_step got=%h exp=%h", nm, cur, expv);
            end
            if (last >= 0) begin
               checks++;
               if (c - last != 4) begin
                  failures++;
                  $display("FAIL %s_tick_gap got=%0d exp=4", nm, c - last);
               end
            end
            last = c;
            ticks++;
            prev = cur;
            done = (cur == tgt);
         end
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s_timeout got=%h exp=%h", nm, speed, tgt);
      end else if (ticks > 0) begin
         if (ramping !== 1'b1) begin
            failures++;
            $display("FAIL %s_ramping_last got=%b exp=1", nm, ramping);
         end
         step(1);
         checks++;
         if (ramping !== 1'b0) begin
            failures++;
            $display("FAIL %s_ramping_fall got=%b exp=0", nm, ramping);
         end
      end
      step(3);
   endtask

   task automatic test_reset();
      step(2);
      checks++;
      if (speed !== 36'h0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_state got=%h/%b/%h exp=0/0/00", speed, tx_valid, tx_data);
      end
      checks++;
      if (ramping !== 1'b0 || wdog_trip !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b%b%b exp=000", ramping, wdog_trip, overrun);
      end
      rst = 1'b1;
      step(2);
   endtask

   task automatic test_forward(input string nm);
      int t;
      tx_ready = 1'b1;
      send("f", 1'b1, "f");
      checks++;
      if (tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_tx_early got=%b exp=0", nm, tx_valid);
      end
      step(1);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== "f") begin
         failures++;
         $display("FAIL %s_tx_n2 got=%b/%h exp=1/66", nm, tx_valid, tx_data);
      end
      ramp_watch({9'h080, 9'h080, 9'h002, 9'h002}, nm, t);
      checks++;
      if (t != 16) begin
         failures++;
         $display("FAIL %s_ticks got=%0d exp=16", nm, t);
      end
   endtask

   task automatic test_descend_stop();
      int t;
      send("d", 1'b1, "d");
      step(1);
      ramp_watch({4{9'h0FF}}, "down", t);
      checks++;
      if (t != 32) begin
         failures++;
         $display("FAIL down_ticks got=%0d exp=32", t);
      end
      send("s", 1'b1, "s");
      step(1);
      ramp_watch(36'h0, "stop", t);
      checks++;
      if (t != 32) begin
         failures++;
         $display("FAIL stop_ticks got=%0d exp=32", t);
      end
   endtask

   task automatic test_estop();
      tx_ready = 1'b0;
      send("b", 1'b1, "b");
      step(8);
      checks++;
      if (ramping !== 1'b1 || speed == 36'h0) begin
         failures++;
         $display("FAIL estop_pre got=%b/%h exp=1/nonzero", ramping, speed);
      end
      send("e", 1'b0, 8'h00);
      checks++;
      if (speed !== 36'h0) begin
         failures++;
         $display("FAIL estop_speed got=%h exp=0", speed);
      end
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("FAIL estop_overrun got=%b exp=1", overrun);
      end
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== "b") begin
         failures++;
         $display("FAIL estop_ack_held got=%b/%h exp=1/62", tx_valid, tx_data);
      end
      step(1);
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL estop_overrun_width got=%b exp=0", overrun);
      end
      step(10);
      checks++;
      if (speed !== 36'h0 || ramping !== 1'b0 || tx_valid !== 1'b1 || tx_data !== "b") begin
         failures++;
         $display("FAIL estop_hold got=%h/%b/%b/%h exp=0/0/1/62", speed, ramping, tx_valid, tx_data);
      end
      tx_ready = 1'b1;
      step(3);
   endtask

   task automatic test_unknown_overrun();
      int ov;
      send("x", 1'b1, "?");
      step(3);
      checks++;
      if (speed !== 36'h0 || ramping !== 1'b0) begin
         failures++;
         $display("FAIL unknown_tgt got=%h/%b exp=0/0", speed, ramping);
      end
      send("u", 1'b1, "u");
      step(1);
      send("d", 1'b0, 8'h00);
      ov = 0;
      for (int c = 0; c < 6; c++) begin
         if (overrun === 1'b1) ov++;
         step(1);
      end
      checks++;
      if (ov != 1) begin
         failures++;
         $display("FAIL overrun_count got=%0d exp=1", ov);
      end
      step(6);
      checks++;
      if (speed !== {4{9'h002}} || ramping !== 1'b0) begin
         failures++;
         $display("FAIL dropped_byte got=%h/%b exp=%h/0", speed, ramping, {4{9'h002}});
      end
   endtask

   task automatic test_watchdog();
      int k, trips;
      bit found;
      send("u", 1'b1, "u");
      k = 0;
      found = 1'b0;
      for (int c = 1; c <= 150 && !found; c++) begin
         step(1);
         if (wdog_trip === 1'b1) begin
            found = 1'b1;
            k = c;
         end
      end
      checks++;
      if (!found || k != 101) begin
         failures++;
         $display("FAIL wdog_latency got=%0d exp=101", k);
      end
      step(1);
      checks++;
      if (wdog_trip !== 1'b0) begin
         failures++;
         $display("FAIL wdog_width got=%b exp=0", wdog_trip);
      end
      step(6);
      checks++;
      if (speed !== 36'h0 || ramping !== 1'b0) begin
         failures++;
         $display("FAIL wdog_zero got=%h/%b exp=0/0", speed, ramping);
      end
      send("u", 1'b1, "u");
      trips = 0;
      for (int c = 0; c < 98; c++) begin
         if (wdog_trip === 1'b1) trips++;
         step(1);
      end
      send("u", 1'b1, "u");
      for (int c = 0; c < 40; c++) begin
         if (wdog_trip === 1'b1) trips++;
         step(1);
      end
      checks++;
      if (trips != 0) begin
         failures++;
         $display("FAIL wdog_suppress got=%0d exp=0", trips);
      end
   endtask

   task automatic test_reset_mid();
      tx_ready = 1'b0;
      send("d", 1'b0, 8'h00);
      step(6);
      checks++;
      if (ramping !== 1'b1 || tx_valid !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_pre got=%b/%b exp=1/1", ramping, tx_valid);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (speed !== 36'h0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
         failures++;
         $display("FAIL rstmid_async got=%h/%b/%h exp=0/0/00", speed, tx_valid, tx_data);
      end
      checks++;
      if (ramping !== 1'b0 || wdog_trip !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_flags got=%b%b%b exp=000", ramping, wdog_trip, overrun);
      end
      step(2);
      rst = 1'b1;
      tx_ready = 1'b1;
      step(1);
      test_forward("after_rst");
   endtask

   initial begin
      test_reset();
      test_forward("fwd");
      test_descend_stop();
      test_estop();
      test_unknown_overrun();
      test_watchdog();
      test_reset_mid();
      step(4);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL ack_missing got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
